// File: rtl/wb_pkg.sv
// Shared defaults and entry layout for the writeback queue and its forwarding logic.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match lookup of one register read index against the occupied queue entries.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic [ADDR_W-1:0]         rs,
  input  logic [ADDR_W-1:0]         rd_mem   [DEPTH],
  input  logic [DATA_W-1:0]         data_mem [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic [$clog2(DEPTH):0]    count,
  output logic                      hit,
  output logic [DATA_W-1:0]         data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] RD_ZERO   = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Walk oldest to youngest so the last match, the youngest write, wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = DATA_ZERO;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W + 1)'(i) < count) && (rs != RD_ZERO) && (rd_mem[idx] == rs)) begin
        hit  = 1'b1;
        data = data_mem[idx];
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Circular FIFO of pending register-file writes with in-order drain and read-port forwarding.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [ADDR_W-1:0]        inRd,
  input  logic [DATA_W-1:0]        inData,
  input  logic                     hold,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        rd,
  output logic [DATA_W-1:0]        dataWrite,
  input  logic [ADDR_W-1:0]        rs0,
  input  logic [ADDR_W-1:0]        rs1,
  output logic                     fwdHit0,
  output logic                     fwdHit1,
  output logic [DATA_W-1:0]        fwdData0,
  output logic [DATA_W-1:0]        fwdData1,
  output logic [$clog2(DEPTH):0]   count
);

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ZERO  = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] RD_ZERO   = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [ADDR_W-1:0] rd_mem_r   [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W:0]    count_r;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  // Handshake, drain port and push/pop decisions, all from registered state.
  always_comb begin
    empty_s  = (count_r == CNT_ZERO);
    inReady  = (count_r < CNT_FULL);
    regWrite = !empty_s && !hold;
    count    = count_r;
    if (empty_s) begin
      rd        = RD_ZERO;
      dataWrite = DATA_ZERO;
    end else begin
      rd        = rd_mem_r[head_r];
      dataWrite = data_mem_r[head_r];
    end
    // Writes to register 0 complete the handshake but are dropped.
    push_s = inValid && inReady && (inRd != RD_ZERO);
    pop_s  = regWrite;
  end

  // Entry storage; unoccupied slots are never visible, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      rd_mem_r[tail_r]   <= inRd;
      data_mem_r[tail_r] <= inData;
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  wb_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd0 (
    .rs       (rs0),
    .rd_mem   (rd_mem_r),
    .data_mem (data_mem_r),
    .head     (head_r),
    .count    (count_r),
    .hit      (fwdHit0),
    .data     (fwdData0)
  );

  wb_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd1 (
    .rs       (rs1),
    .rd_mem   (rd_mem_r),
    .data_mem (data_mem_r),
    .head     (head_r),
    .count    (count_r),
    .hit      (fwdHit1),
    .data     (fwdData1)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Directed and randomized bench for writeback_queue against a queue-based reference model.
module tb_writeback_queue;
  import wb_pkg::*;

  logic        CLK;
  logic        RESETn;
  logic        inValid;
  logic        inReady;
  logic [3:0]  inRd;
  logic [15:0] inData;
  logic        hold;
  logic        regWrite;
  logic [3:0]  rd;
  logic [15:0] dataWrite;
  logic [3:0]  rs0;
  logic [3:0]  rs1;
  logic        fwdHit0;
  logic        fwdHit1;
  logic [15:0] fwdData0;
  logic [15:0] fwdData1;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  wb_entry_t q[$];

  writeback_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .inValid(inValid), .inReady(inReady),
    .inRd(inRd), .inData(inData), .hold(hold), .regWrite(regWrite),
    .rd(rd), .dataWrite(dataWrite), .rs0(rs0), .rs1(rs1),
    .fwdHit0(fwdHit0), .fwdHit1(fwdHit1), .fwdData0(fwdData0),
    .fwdData1(fwdData1), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to rs, from the model queue.
  task automatic lookup(input logic [3:0] rs, output logic hit, output logic [15:0] d);
    hit = 1'b0;
    d   = 16'd0;
    if (rs != 4'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].rd == rs) begin
          hit = 1'b1;
          d   = q[i].data;
          break;
        end
      end
    end
  endtask

  task automatic compare_all();
    int n;
    logic h0, h1;
    logic [15:0] d0, d1;
    n = q.size();
    check("count", 32'(count), 32'(n));
    check("inReady", 32'(inReady), 32'(n < 4));
    check("regWrite", 32'(regWrite), 32'((n != 0) && !hold));
    check("rd", 32'(rd), (n != 0) ? 32'(q[0].rd) : 32'd0);
    check("dataWrite", 32'(dataWrite), (n != 0) ? 32'(q[0].data) : 32'd0);
    lookup(rs0, h0, d0);
    lookup(rs1, h1, d1);
    check("fwdHit0", 32'(fwdHit0), 32'(h0));
    check("fwdData0", 32'(fwdData0), 32'(d0));
    check("fwdHit1", 32'(fwdHit1), 32'(h1));
    check("fwdData1", 32'(fwdData1), 32'(d1));
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [15:0] d,
                       input logic h, input logic [3:0] r0, input logic [3:0] r1);
    @(negedge CLK);
    inValid = v; inRd = a; inData = d; hold = h; rs0 = r0; rs1 = r1;
    #1;
    compare_all();
  endtask

  // Advance one edge and apply the handshake rules to the model.
  task automatic tick();
    bit we, acc;
    wb_entry_t e;
    we    = (q.size() != 0) && !hold;
    acc   = inValid && (q.size() < 4) && (inRd != 4'd0);
    e.rd   = inRd;
    e.data = inData;
    @(posedge CLK);
    if (we) void'(q.pop_front());
    if (acc) q.push_back(e);
  endtask

  initial begin
    RESETn = 1'b0; inValid = 1'b0; inRd = 4'd0; inData = 16'd0;
    hold = 1'b0; rs0 = 4'd0; rs1 = 4'd0;
    #1;
    compare_all();
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;

    // Minimum latency single write.
    drive(1'b1, 4'd3, 16'd15, 1'b0, 4'd3, 4'd0);
    check("lat_fwd_same_cycle", 32'(fwdHit0), 32'd0);
    tick();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd3, 4'd0);
    check("lat_we", 32'(regWrite), 32'd1);
    check("lat_rd", 32'(rd), 32'd3);
    check("lat_data", 32'(dataWrite), 32'd15);
    tick();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0);
    check("lat_count", 32'(count), 32'd0);
    tick();

    // Fill under hold, reject fifth offer, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 16'(i), 1'b1, 4'd0, 4'd0);
      tick();
    end
    drive(1'b1, 4'd5, 16'd5, 1'b1, 4'd0, 4'd0);
    check("full_ready", 32'(inReady), 32'd0);
    check("full_count", 32'(count), 32'd4);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0);
      check("drain_we", 32'(regWrite), 32'd1);
      check("drain_rd", 32'(rd), 32'(i));
      check("drain_data", 32'(dataWrite), 32'(i));
      tick();
    end

    // Same-rd entries: youngest forwarded, accepting offer not forwarded.
    drive(1'b1, 4'd5, 16'd10, 1'b1, 4'd5, 4'd0);
    tick();
    drive(1'b1, 4'd5, 16'd20, 1'b1, 4'd5, 4'd0);
    check("fwd_pending_old", 32'(fwdData0), 32'd10);
    tick();
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 4'd0);
    check("fwd_hit0", 32'(fwdHit0), 32'd1);
    check("fwd_data0", 32'(fwdData0), 32'd20);
    check("fwd_hit1_r0", 32'(fwdHit1), 32'd0);
    check("fwd_data1_r0", 32'(fwdData1), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd5, 4'd5);
      tick();
    end

    // Offer to register 0 is swallowed.
    drive(1'b1, 4'd0, 16'd15, 1'b0, 4'd0, 4'd0);
    check("r0_ready", 32'(inReady), 32'd1);
    tick();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0);
    check("r0_count", 32'(count), 32'd0);
    check("r0_we", 32'(regWrite), 32'd0);
    tick();

    // Reset mid-drain.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(7 + i), 16'(100 + i), 1'b1, 4'd0, 4'd0);
      tick();
    end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd8, 4'd9);
    tick();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd8, 4'd9);
    check("mid_drain_we", 32'(regWrite), 32'd1);
    RESETn = 1'b0;
    #1;
    q.delete();
    check("rst_we", 32'(regWrite), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    compare_all();
    @(negedge CLK);
    RESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd8, 4'd9);
      check("post_rst_we", 32'(regWrite), 32'd0);
      tick();
    end

    // Full queue streaming: one pop plus one push per cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(1 + i), 16'(200 + i), 1'b1, 4'd0, 4'd0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(1 + (i % 15)), 16'(300 + i), 1'b0, 4'(i % 5), 4'(i % 3));
      if (i >= 1) check("stream_count", 32'(count), 32'd3);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd1, 4'd2);
      tick();
    end

    // Randomized traffic with small rd range to provoke forwarding collisions.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 5)), 16'($urandom),
            1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DATA_W, default 16, shall set the register data width.
REQ-002 Parameter ADDR_W, default 4, shall set the register index width (16 registers).
REQ-003 Parameter DEPTH, default 4, shall set the number of pending-write entries (power of two).
REQ-004 Port CLK  in  1: the single clock; all state shall update on the rising edge.
REQ-005 Port RESETn  in  1: reset, asynchronous and active-low.
REQ-006 Port inValid  in  1: a producer offers a write result.
REQ-007 Port inReady  out  1: the queue accepts the offer.
REQ-008 Port inRd  in  ADDR_W: destination register of the offer.
REQ-009 Port inData  in  DATA_W: data of the offer.
REQ-010 Port hold  in  1: suppresses draining to the register file.
REQ-011 Port regWrite  out  1: write enable to the register file.
REQ-012 Port rd  out  ADDR_W: register file write index.
REQ-013 Port dataWrite  out  DATA_W: register file write data.
REQ-014 Ports rs0, rs1  in  ADDR_W each: read indices presented to the register file, snooped here.
REQ-015 Ports fwdHit0, fwdHit1  out  1 each: a pending entry matches rs0 / rs1.
REQ-016 Ports fwdData0, fwdData1  out  DATA_W each: forwarded data for rs0 / rs1.
REQ-017 Port count  out  $clog2(DEPTH)+1: number of occupied entries.

Function
REQ-018 Storage shall be a circular FIFO of {rd, data} entries with head and tail pointers that wrap modulo DEPTH.
REQ-019 Push shall occur on an edge where inValid=1 and inReady=1 and inRd!=0.
REQ-020 An offer with inRd=0 shall be accepted (handshake completes) and discarded; count shall not change.
REQ-021 inReady shall equal (count<DEPTH), combinationally from registered state only.
REQ-022 regWrite shall equal (count!=0 && hold==0); rd and dataWrite shall show the head entry while count!=0, else 0.
REQ-023 Pop shall occur on every edge where regWrite=1; the register file captures the head on that same edge.
REQ-024 Simultaneous push and pop shall leave count unchanged; ordering shall be strictly FIFO.
REQ-025 Minimum latency: an entry pushed at edge N into an empty queue with hold=0 shall drive regWrite=1 during cycle N+1 and be written at edge N+1.
REQ-026 hold=1 shall freeze pop only; pushes continue until full.
REQ-027 fwdHitK shall be 1 when rsK!=0 and any occupied entry (head included) has rd==rsK; fwdDataK shall be the data of the youngest such entry, else 0.
REQ-028 The offer being accepted in the current cycle shall not be forwarded; it is forwardable from the next cycle.
REQ-029 Forwarding outputs shall be purely combinational from rs0/rs1 and stored state.
REQ-030 Multiple pending entries to the same rd shall all be retained and drained in order (no coalescing).

Reset
REQ-031 RESETn=0 shall immediately clear head, tail and count to 0, discarding pending entries, including mid-drain.
REQ-032 During and after reset: inReady=1, regWrite=0, rd=0, dataWrite=0, fwdHit0/1=0, fwdData0/1=0, count=0.
REQ-033 Entry storage need not be reset; it shall never be observable while its slot is unoccupied.

Structure
REQ-034 A shared package wb_pkg shall hold DATA_W, ADDR_W and DEPTH defaults and the entry typedef {rd, data}.
REQ-035 Forwarding priority-match logic shall be one sub-module, wb_fwd_match, instantiated once per read port.

Verification
REQ-036 Reset then push (inRd=3, inData=15), hold=0 -> next cycle regWrite=1, rd=3, dataWrite=15; following cycle count=0.
REQ-037 hold=1, push r1..r4 with data 1..4, then a fifth offer -> inReady=0, count=4; release hold -> four writes r1..r4 in order on consecutive cycles.
REQ-038 hold=1, push (r5,10) then (r5,20), rs0=5 -> fwdHit0=1, fwdData0=20; rs1=0 -> fwdHit1=0, fwdData1=0.
REQ-039 Offer inRd=0, inData=15 -> accepted, count stays 0, regWrite never asserts.
REQ-040 Queue holding 3 entries, assert RESETn=0 mid-drain -> regWrite=0 and count=0 immediately; no further writes after release.
REQ-041 Queue full with hold=0, continuous offers -> one pop and one push per cycle after first freeing, count stable, all data written in order.
